proc_spawn_queue: RTL and testbench
===================================

# proc_spawn_queue

Upstream feeder for the thread scheduler: accepts process-spawn requests (start address) from the CPU message path, allocates a process ID, and queues `{id, addr}` pairs. The scheduler drains the queue into its pending-process table through a valid/ready handshake. ID 0 is reserved for the boot process, which the scheduler owns from reset; this block never hands it out.

## Interface
Parameters:
- `DEPTH`, 8: queue entries; power of two, ≥2.
- `MAX_PROCS`, 8: size of the process-ID space; IDs 1..MAX_PROCS-1 are allocatable.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `spawn_valid`  in  1  spawn request present
- `spawn_addr`  in  32  start address of the new process
- `spawn_ready`  out  1  request accepted this cycle when high with `spawn_valid`
- `exit_valid`  in  1  process termination notice
- `exit_id`  in  32  ID being released
- `out_valid`  out  1  queue head valid
- `out_id`  out  32  head process ID
- `out_addr`  out  32  head start address
- `out_ready`  in  1  scheduler takes the head
- `count`  out  8  queue occupancy, 0..DEPTH
- `ids_exhausted`  out  1  no ID allocatable
- `err_bad_exit`  out  1  one-cycle pulse on an invalid release

## Operation
- ID allocator state: `in_use` bitmap of MAX_PROCS bits; bit 0 is permanently set.
  - With recycling, the allocated ID is the lowest-numbered clear bit.
  - Without recycling, IDs come from a counter `next_id` that starts at 1 and increments on each allocation.
- `id_avail` comes from registered state only.
  - With recycling: any bit is clear.
  - Without recycling: `next_id < MAX_PROCS`.
  - `ids_exhausted = !id_avail`.
- `spawn_ready = !rst && !full && id_avail`, computed from registered state only. There is no combinational path from `out_ready` or `exit_valid`.
- Push (spawn_valid && spawn_ready):
  - writes `{alloc_id, spawn_addr}` at the tail;
  - sets `in_use[alloc_id]`;
  - advances the tail pointer modulo DEPTH.
- Pop (out_valid && out_ready): advances the head pointer modulo DEPTH. The queue is first-word-fall-through; `out_id` and `out_addr` always show the head entry.
- Simultaneous push and pop: `count` is unchanged and both pointers advance. When the queue is full, `spawn_ready` is 0, so a pop in that cycle frees the slot for the next cycle only.
- Empty: `out_valid=0`, and `out_id`/`out_addr` hold their last values. Pop is ignored when `out_valid=0`.
- Release (exit_valid):
  - Valid when `1 ≤ exit_id < MAX_PROCS` and `in_use[exit_id]=1`; the bit is cleared at the clock edge.
  - Otherwise: no state change and `err_bad_exit` pulses the next cycle.
  - Because allocation reads the registered bitmap, an ID released in cycle N is allocatable from cycle N+1 at the earliest.
  - Releasing an ID still sitting in the queue is legal, and the entry stays queued. Catching this misuse is the caller's responsibility.
- Pointers are log2(DEPTH) bits plus one wrap bit. `full` means the pointers are equal with opposite wrap bits; `empty` means the pointers are equal with the same wrap bits.

## Timing
- Reset, with `rst` high at a clock edge:
  - `out_valid=0`, `out_id=0`, `out_addr=0`, `count=0`, `err_bad_exit=0`;
  - pointers 0, `in_use=1` (only bit 0 set), `next_id=1`.
- `spawn_ready` reads 0 while `rst` is high and 1 in the first cycle after.
- Reset during operation discards all queued entries and allocations in one cycle.
- Latency: a spawn accepted at edge N gives `out_valid=1` and `count` updated after edge N (visible in cycle N+1).
- Throughput: one push and one pop per cycle.
- `ids_exhausted` updates the cycle after the allocation or release that changes it.
- `err_bad_exit` is high for exactly one cycle per bad release.

## Configuration
- `PROC_ID_RECYCLE_EN` defined:
  - bitmap allocator, lowest free ID first;
  - `exit_valid` releases IDs as described above.
- Not defined:
  - monotonic `next_id` allocator;
  - `exit_valid`/`exit_id` are ignored and `err_bad_exit` stays 0;
  - after MAX_PROCS-1 spawns, `ids_exhausted=1` until reset.

## Test plan
- Reset, then 3 spawns (addr 0x100, 0x200, 0x300) with `out_ready=0` -> `count=3`; head `out_id=1`, `out_addr=0x100`; pops then return IDs 2 and 3 in order.
- DEPTH=8, MAX_PROCS=16, 8 spawns with no pops -> `spawn_ready=0` at `count=8`. One pop and a spawn held in the same cycle -> `count=7` in that cycle, the push accepted the next cycle, back to `count=8`.
- MAX_PROCS=8, 7 spawns popped as issued -> `ids_exhausted=1`, `spawn_ready=0`. With recycling, exit_id=3 -> the next spawn gets `out_id=3`.
- With recycling, exit_id=0, then exit_id=5 while ID 5 is unallocated, then exit_id=9 -> `err_bad_exit` pulses three times and `in_use` is unchanged.
- Spawn and pop every cycle for 20 cycles with recycling and matching exits -> `count` constant at 1, IDs in the expected order, pointers wrap cleanly.
- `rst` asserted with `count=4` -> the next cycle shows `count=0`, `out_valid=0`, `spawn_ready=1`; the next spawn gets `out_id=1`.

Source files
------------

// File: rtl/proc_spawn_queue.sv
// Spawn-request queue: allocates process IDs and queues {id, addr} pairs for the scheduler.
// Define PROC_ID_RECYCLE_EN for the bitmap allocator with ID release; otherwise IDs are monotonic.
module proc_spawn_queue #(
  parameter int DEPTH     = 8,
  parameter int MAX_PROCS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spawn_valid,
  input  logic [31:0] spawn_addr,
  output logic        spawn_ready,
  input  logic        exit_valid,
  input  logic [31:0] exit_id,
  output logic        out_valid,
  output logic [31:0] out_id,
  output logic [31:0] out_addr,
  input  logic        out_ready,
  output logic [7:0]  count,
  output logic        ids_exhausted,
  output logic        err_bad_exit
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(MAX_PROCS);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]  wptr, rptr, wptr_nxt, rptr_nxt, occ;
  logic [31:0]  id_mem   [DEPTH];
  logic [31:0]  addr_mem [DEPTH];
  logic         full, empty, empty_nxt, push, pop, id_avail;
  logic [31:0]  alloc_id;

  assign full        = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty       = (wptr == rptr);
  assign spawn_ready = !rst && !full && id_avail;
  assign push        = spawn_valid && spawn_ready;
  assign out_valid   = !empty;
  assign pop         = out_valid && out_ready;
  assign wptr_nxt    = push ? wptr + PTR_ONE : wptr;
  assign rptr_nxt    = pop ? rptr + PTR_ONE : rptr;
  assign empty_nxt   = (wptr_nxt == rptr_nxt);
  assign occ         = wptr - rptr;
  assign count       = 8'(occ);
  assign ids_exhausted = !id_avail;

  always_ff @(posedge clk) begin
    if (push) begin
      id_mem[wptr[AW-1:0]]   <= alloc_id;
      addr_mem[wptr[AW-1:0]] <= spawn_addr;
    end
  end

  // Head is registered; a push landing in the next head slot bypasses the memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      out_id   <= '0;
      out_addr <= '0;
    end else begin
      wptr <= wptr_nxt;
      rptr <= rptr_nxt;
      if (!empty_nxt) begin
        if (push && (rptr_nxt[AW-1:0] == wptr[AW-1:0])) begin
          out_id   <= alloc_id;
          out_addr <= spawn_addr;
        end else begin
          out_id   <= id_mem[rptr_nxt[AW-1:0]];
          out_addr <= addr_mem[rptr_nxt[AW-1:0]];
        end
      end
    end
  end

`ifdef PROC_ID_RECYCLE_EN
  logic [MAX_PROCS-1:0] in_use;
  logic [IW-1:0]        alloc_idx;
  logic                 release_ok;

  // Scan downward so the lowest free ID wins; bit 0 is never a candidate.
  always_comb begin
    alloc_idx = '0;
    for (int i = MAX_PROCS - 1; i >= 1; i--) begin
      if (!in_use[i]) alloc_idx = IW'(i);
    end
  end

  assign alloc_id   = 32'(alloc_idx);
  assign id_avail   = !(&in_use);
  assign release_ok = exit_valid && (exit_id != 32'd0) && (exit_id < 32'(MAX_PROCS))
                      && in_use[exit_id[IW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      in_use       <= MAX_PROCS'(1);
      err_bad_exit <= 1'b0;
    end else begin
      if (push) in_use[alloc_idx] <= 1'b1;
      if (release_ok) in_use[exit_id[IW-1:0]] <= 1'b0;
      err_bad_exit <= exit_valid && !release_ok;
    end
  end
`else
  logic [31:0] next_id;
  logic        unused_exit;

  assign alloc_id     = next_id;
  assign id_avail     = (next_id < 32'(MAX_PROCS));
  assign err_bad_exit = 1'b0;
  assign unused_exit  = ^{exit_valid, exit_id};

  always_ff @(posedge clk) begin
    if (rst) next_id <= 32'd1;
    else if (push) next_id <= next_id + 32'd1;
  end
`endif

endmodule

// File: tb/tb_proc_spawn_queue.sv
// Directed self-checking bench for proc_spawn_queue (DEPTH=8, MAX_PROCS=16).
// Recycling checks run when PROC_ID_RECYCLE_EN is defined; otherwise the monotonic allocator is checked.
module tb_proc_spawn_queue;

  logic        clk;
  logic        rst;
  logic        spawn_valid;
  logic [31:0] spawn_addr;
  logic        spawn_ready;
  logic        exit_valid;
  logic [31:0] exit_id;
  logic        out_valid;
  logic [31:0] out_id;
  logic [31:0] out_addr;
  logic        out_ready;
  logic [7:0]  count;
  logic        ids_exhausted;
  logic        err_bad_exit;

  int n_checks = 0;
  int n_fails  = 0;

  proc_spawn_queue #(.DEPTH(8), .MAX_PROCS(16)) dut (
    .clk(clk), .rst(rst),
    .spawn_valid(spawn_valid), .spawn_addr(spawn_addr), .spawn_ready(spawn_ready),
    .exit_valid(exit_valid), .exit_id(exit_id),
    .out_valid(out_valid), .out_id(out_id), .out_addr(out_addr), .out_ready(out_ready),
    .count(count), .ids_exhausted(ids_exhausted), .err_bad_exit(err_bad_exit)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic sv, input logic [31:0] addr, input logic ordy,
                               input logic ev, input logic [31:0] eid);
    spawn_valid = sv;
    spawn_addr  = addr;
    out_ready   = ordy;
    exit_valid  = ev;
    exit_id     = eid;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] exp_head;
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    checkOutput("rst_spawn_ready", 32'(spawn_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_id", out_id, 32'd0);
    checkOutput("rst_out_addr", out_addr, 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_err", 32'(err_bad_exit), 32'd0);
    checkOutput("rst_exhausted", 32'(ids_exhausted), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_spawn_ready", 32'(spawn_ready), 32'd1);

    $display("[TB] three spawns then drain");
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0); tick();
    checkOutput("first_out_valid", 32'(out_valid), 32'd1);
    checkOutput("first_count", 32'(count), 32'd1);
    applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, 32'h0); tick();
    applyStimulus(1'b1, 32'h300, 1'b0, 1'b0, 32'h0); tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("three_count", 32'(count), 32'd3);
    checkOutput("three_head_id", out_id, 32'd1);
    checkOutput("three_head_addr", out_addr, 32'h100);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0); tick();
    checkOutput("pop1_id", out_id, 32'd2);
    checkOutput("pop1_addr", out_addr, 32'h200);
    checkOutput("pop1_count", 32'(count), 32'd2);
    tick();
    checkOutput("pop2_id", out_id, 32'd3);
    checkOutput("pop2_addr", out_addr, 32'h300);
    tick();
    checkOutput("drained_valid", 32'(out_valid), 32'd0);
    checkOutput("drained_count", 32'(count), 32'd0);
    checkOutput("drained_hold_id", out_id, 32'd3);
    checkOutput("drained_hold_addr", out_addr, 32'h300);
    tick();
    checkOutput("empty_pop_ignored", 32'(count), 32'd0);

    $display("[TB] fill to full");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 32'h1000 + 32'(i), 1'b0, 1'b0, 32'h0);
      tick();
      checkOutput("fill_count", 32'(count), 32'(i + 1));
    end
    checkOutput("full_spawn_ready", 32'(spawn_ready), 32'd0);
    checkOutput("full_head_id", out_id, 32'd4);
    applyStimulus(1'b1, 32'h2000, 1'b1, 1'b0, 32'h0); tick();
    checkOutput("full_pop_count", 32'(count), 32'd7);
    checkOutput("full_pop_ready", 32'(spawn_ready), 32'd1);
    checkOutput("full_pop_head", out_id, 32'd5);
    applyStimulus(1'b1, 32'h2000, 1'b0, 1'b0, 32'h0); tick();
    checkOutput("refill_count", 32'(count), 32'd8);
    checkOutput("refill_ready", 32'(spawn_ready), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    for (int k = 1; k <= 7; k++) begin
      tick();
      checkOutput("drain_id", out_id, 32'(5 + k));
    end
    checkOutput("drain_last_addr", out_addr, 32'h2000);
    checkOutput("drain_last_count", 32'(count), 32'd1);
    tick();
    checkOutput("drain_empty", 32'(out_valid), 32'd0);
    checkOutput("pre_exhaust", 32'(ids_exhausted), 32'd0);

    $display("[TB] exhaust ID space");
    applyStimulus(1'b1, 32'h4000, 1'b1, 1'b0, 32'h0); tick();
    checkOutput("exh1_id", out_id, 32'd13);
    tick();
    checkOutput("exh2_id", out_id, 32'd14);
    checkOutput("exh2_count", 32'(count), 32'd1);
    tick();
    checkOutput("exh3_id", out_id, 32'd15);
    checkOutput("exh_flag", 32'(ids_exhausted), 32'd1);
    checkOutput("exh_ready", 32'(spawn_ready), 32'd0);
    tick();
    checkOutput("exh_drained", 32'(out_valid), 32'd0);
    checkOutput("exh_hold", 32'(ids_exhausted), 32'd1);

`ifdef PROC_ID_RECYCLE_EN
    $display("[TB] recycling");
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'd3); tick();
    checkOutput("rel3_exhausted", 32'(ids_exhausted), 32'd0);
    checkOutput("rel3_ready", 32'(spawn_ready), 32'd1);
    checkOutput("rel3_err", 32'(err_bad_exit), 32'd0);
    applyStimulus(1'b1, 32'h3000, 1'b0, 1'b0, 32'h0); tick();
    checkOutput("reuse3_id", out_id, 32'd3);
    checkOutput("reuse3_addr", out_addr, 32'h3000);
    checkOutput("reuse3_exhausted", 32'(ids_exhausted), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0); tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'd5); tick();
    checkOutput("rel5_err", 32'(err_bad_exit), 32'd0);
    checkOutput("rel5_exhausted", 32'(ids_exhausted), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'd0); tick();
    checkOutput("bad0_err", 32'(err_bad_exit), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0); tick();
    checkOutput("bad0_pulse_end", 32'(err_bad_exit), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'd5); tick();
    checkOutput("bad5_err", 32'(err_bad_exit), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0); tick();
    checkOutput("bad5_pulse_end", 32'(err_bad_exit), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'd16); tick();
    checkOutput("bad16_err", 32'(err_bad_exit), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0); tick();
    checkOutput("bad16_pulse_end", 32'(err_bad_exit), 32'd0);
    checkOutput("bad_bitmap_kept", 32'(ids_exhausted), 32'd0);
    applyStimulus(1'b1, 32'h5000, 1'b0, 1'b0, 32'h0); tick();
    checkOutput("reuse5_id", out_id, 32'd5);
    checkOutput("reuse5_exhausted", 32'(ids_exhausted), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0); tick();

    $display("[TB] streaming with matching exits");
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'd1); tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'd2); tick();
    applyStimulus(1'b1, 32'h6000, 1'b0, 1'b0, 32'h0); tick();
    checkOutput("stream_seed_id", out_id, 32'd1);
    exp_head = 32'd1;
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1'b1, 32'h7000 + 32'(k), 1'b1, 1'b1, exp_head);
      tick();
      exp_head = (exp_head == 32'd1) ? 32'd2 : 32'd1;
      checkOutput("stream_id", out_id, exp_head);
      checkOutput("stream_addr", out_addr, 32'h7000 + 32'(k));
      checkOutput("stream_count", 32'(count), 32'd1);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0); tick();
    checkOutput("stream_err", 32'(err_bad_exit), 32'd0);
`else
    $display("[TB] exits ignored without recycling");
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'd3); tick();
    checkOutput("norec_exhausted", 32'(ids_exhausted), 32'd1);
    checkOutput("norec_ready", 32'(spawn_ready), 32'd0);
    checkOutput("norec_err3", 32'(err_bad_exit), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'd0); tick();
    checkOutput("norec_err0", 32'(err_bad_exit), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0); tick();
`endif

    $display("[TB] reset during operation");
    rst = 1'b1; tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h800 + 32'(i), 1'b0, 1'b0, 32'h0);
      tick();
    end
    checkOutput("pre_rst_count", 32'(count), 32'd4);
    checkOutput("pre_rst_head", out_id, 32'd1);
    rst = 1'b1; tick();
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("mid_rst_count", 32'(count), 32'd0);
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_ready", 32'(spawn_ready), 32'd1);
    checkOutput("mid_rst_out_id", out_id, 32'd0);
    applyStimulus(1'b1, 32'h500, 1'b0, 1'b0, 32'h0); tick();
    checkOutput("after_rst_id", out_id, 32'd1);
    checkOutput("after_rst_addr", out_addr, 32'h500);
    checkOutput("after_rst_count", 32'(count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
